rr_token_arbiter: RTL and testbench

- Round-robin arbiter that shares one upstream req/ack producer channel among NUM_REQ downstream requesters.
- Used where one async operator output, or one bench producer, must feed several independent consumers in turn rather than in lockstep broadcast.
- Speaks the existing single-cycle-ack handshake on both sides.
- Fixed 4-cycle transfer cadence, so the throughput metric (count / (cycles/4)) reads 100% for a lone always-requesting consumer.

---
 rtl/rr_token_arbiter_pkg.sv | 18 +
 rtl/rr_token_arbiter_if.sv | 25 ++
 rtl/rr_pick.sv | 29 ++
 rtl/rr_token_arbiter.sv | 91 +++++++++
 tb/tb_rr_token_arbiter.sv | 320 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rr_token_arbiter_pkg.sv
// rtl/rr_token_arbiter_pkg.sv - shared state encoding and width helper for the round-robin token arbiter
package rr_token_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DELIVER = 2'd2
    } arb_state_t;

    // Index width for n entries, never below one bit.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_token_arbiter_if.sv
// rtl/rr_token_arbiter_if.sv - upstream producer channel plus downstream requester channels
interface rr_token_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
);
    logic                  req_up;
    logic                  ack_up;
    logic [DATA_WIDTH-1:0] din_up;
    logic [NUM_REQ-1:0]    req_dn;
    logic [NUM_REQ-1:0]    ack_dn;
    logic [DATA_WIDTH-1:0] dout_dn;
    logic [ID_WIDTH-1:0]   grant_id;
    logic                  busy;

    modport master (
        output req_up, ack_dn, dout_dn, grant_id, busy,
        input  ack_up, din_up, req_dn
    );

    modport slave (
        input  req_up, ack_dn, dout_dn, grant_id, busy,
        output ack_up, din_up, req_dn
    );
endinterface

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin selector: first set request after the last grantee
module rr_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last,
    output logic                found,
    output logic [ID_WIDTH-1:0] idx
);
    int                  cand;
    logic [ID_WIDTH-1:0] cand_idx;

    // Walk from the farthest offset back to the nearest so the nearest hit wins.
    always_comb begin
        found    = 1'b0;
        idx      = '0;
        cand     = 0;
        cand_idx = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand     = int'((32'(last) + 32'(off)) % 32'(NUM_REQ));
            cand_idx = ID_WIDTH'(cand);
            if (req[cand_idx]) begin
                found = 1'b1;
                idx   = cand_idx;
            end
        end
    end
endmodule

// File: rtl/rr_token_arbiter.sv
// rtl/rr_token_arbiter.sv - shares one upstream req/ack producer among NUM_REQ requesters in round-robin order
module rr_token_arbiter
    import rr_token_arbiter_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ID_WIDTH   = 2
) (
    input logic                clk,
    input logic                rst,
    rr_token_arbiter_if.master bus
);
    if (ID_WIDTH != clog2_min1(NUM_REQ)) begin : g_id_width_check
        $error("rr_token_arbiter: ID_WIDTH must equal clog2(NUM_REQ)");
    end

    // Reset points the pointer at the last port so the first search begins at port 0.
    localparam logic [ID_WIDTH-1:0] LAST_INIT = ID_WIDTH'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0]  ONE_HOT0  = NUM_REQ'(1);

    arb_state_t            state;
    logic                  req_up_q;
    logic                  busy_q;
    logic [NUM_REQ-1:0]    ack_q;
    logic [DATA_WIDTH-1:0] token_q;
    logic [ID_WIDTH-1:0]   grant_q;
    logic [ID_WIDTH-1:0]   last_q;
    logic                  pick_found;
    logic [ID_WIDTH-1:0]   pick_idx;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req   (bus.req_dn),
        .last  (last_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            req_up_q <= 1'b0;
            busy_q   <= 1'b0;
            ack_q    <= '0;
            token_q  <= '0;
            grant_q  <= '0;
            last_q   <= LAST_INIT;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack_q <= '0;
                    if (pick_found) begin
                        grant_q  <= pick_idx;
                        last_q   <= pick_idx;
                        req_up_q <= 1'b1;
                        busy_q   <= 1'b1;
                        state    <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    // The grantee is committed here; its token goes out even if it drops req_dn.
                    if (bus.ack_up) begin
                        token_q  <= bus.din_up;
                        req_up_q <= 1'b0;
                        ack_q    <= ONE_HOT0 << grant_q;
                        state    <= ST_DELIVER;
                    end
                end
                ST_DELIVER: begin
                    ack_q  <= '0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    req_up_q <= 1'b0;
                    busy_q   <= 1'b0;
                    ack_q    <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_up   = req_up_q;
    assign bus.ack_dn   = ack_q;
    assign bus.dout_dn  = token_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_rr_token_arbiter.sv
// tb/tb_rr_token_arbiter.sv - scoreboard bench for rr_token_arbiter with a randomized producer
module tb_rr_token_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    localparam int IW = 2;

    typedef struct {
        int          port;
        logic [31:0] tok;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc;

    rr_token_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

    rr_token_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          tests = 0;
    int          fails = 0;
    exp_t        sb_q[$];
    int          fail_rate = 0;
    int          spurious_en = 0;
    int          tok_limit = 0;
    int          tokens_issued = 0;
    logic [31:0] cnt = 0;
    int          cur_port = 0;
    int          m_last = NR - 1;
    int          delivered = 0;
    int          port_cnt[NR];
    int          last_tok[NR];
    int          last_obs = -1;
    int          rel_cyc = 0;
    int          phase = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Producer: answers a held req_up one cycle after first seeing it, with optional stalls.
    initial begin : producer
        logic req_seen;
        logic ack_was;
        req_seen = 1'b0;
        ack_was  = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                bus.ack_up = 1'b0;
                req_seen   = 1'b0;
                ack_was    = 1'b0;
            end else begin
                bus.ack_up = 1'b0;
                bus.din_up = $urandom();
                if (!ack_was && req_seen && bus.req_up && tokens_issued < tok_limit &&
                    $urandom_range(99) >= fail_rate) begin
                    bus.ack_up = 1'b1;
                    bus.din_up = cnt;
                    sb_q.push_back('{port: cur_port, tok: cnt});
                    cnt++;
                    tokens_issued++;
                end else if (!ack_was && !bus.req_up && spurious_en != 0 &&
                             $urandom_range(99) < 20) begin
                    bus.ack_up = 1'b1;
                end
                ack_was  = bus.ack_up;
                req_seen = bus.req_up;
            end
        end
    end

    // Reference model: on each new request cycle, grant the first active port after the previous grantee.
    initial begin : predictor
        logic       prev_up;
        logic [3:0] req_rec;
        int         p;
        prev_up = 1'b0;
        req_rec = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_last  = NR - 1;
                sb_q.delete();
                prev_up = 1'b0;
            end else begin
                if (bus.req_up && !prev_up) begin
                    p = -1;
                    for (int k = 1; k <= NR; k++) begin
                        if (p < 0 && req_rec[(m_last + k) % NR]) p = (m_last + k) % NR;
                    end
                    check("arb_has_request", 32'(p >= 0), 32'd1);
                    if (p >= 0) begin
                        cur_port = p;
                        m_last   = p;
                    end
                end
                prev_up = bus.req_up;
            end
            req_rec = bus.req_dn;
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && bus.req_up) check("busy_in_wait", 32'(bus.busy), 32'd1);
            if (!rst && bus.ack_dn != '0) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_ack", 32'(bus.ack_dn), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("ack_port", 32'(bus.ack_dn), 32'd1 << e.port);
                    check("token", bus.dout_dn, e.tok);
                    check("grant_id", 32'(bus.grant_id), 32'(e.port));
                    check("busy_in_deliver", 32'(bus.busy), 32'd1);
                    if (last_tok[e.port] >= 0)
                        check("per_port_increasing", 32'(int'(bus.dout_dn) > last_tok[e.port]), 32'd1);
                    if (phase == 1 && last_obs >= 0)
                        check("cadence", 32'(cyc - last_obs), 32'd4);
                    last_tok[e.port] = int'(bus.dout_dn);
                    port_cnt[e.port]++;
                    delivered++;
                    last_obs = cyc;
                end
            end
        end
    end

    task automatic clear_counts();
        delivered     = 0;
        tokens_issued = 0;
        last_obs      = -1;
        for (int i = 0; i < NR; i++) begin
            port_cnt[i] = 0;
            last_tok[i] = -1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_up"}, 32'(bus.req_up), 32'd0);
        check({tag, "_ack_dn"}, 32'(bus.ack_dn), 32'd0);
        check({tag, "_grant_id"}, 32'(bus.grant_id), 32'd0);
        check({tag, "_busy"}, 32'(bus.busy), 32'd0);
        check({tag, "_dout_dn"}, bus.dout_dn, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst        = 1'b1;
        bus.req_dn = '0;
        @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst     = 1'b0;
        rel_cyc = cyc;
        cnt     = 0;
        clear_counts();
    endtask

    task automatic wait_delivered(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (delivered < n && k < budget) begin
            @(posedge clk);
            #3;
            k++;
        end
        check(name, 32'(delivered), 32'(n));
    endtask

    task automatic wait_req_up(input int budget, input int dly, input string name);
        int k;
        k = 0;
        do begin
            @(posedge clk);
            #(dly);
            k++;
        end while (!bus.req_up && k < budget);
        check(name, 32'(bus.req_up), 32'd1);
    endtask

    task automatic drain(input string name);
        int k;
        bus.req_dn = '0;
        @(posedge clk);
        k = 0;
        while (k < 400) begin
            @(posedge clk);
            #3;
            k++;
            if (sb_q.size() == 0 && !bus.req_up && bus.ack_dn == '0) break;
        end
        check(name, 32'(sb_q.size() == 0 && !bus.req_up), 32'd1);
    endtask

    initial begin : stimulus
        int k;
        rst        = 1'b1;
        bus.req_dn = '0;
        bus.ack_up = 1'b0;
        bus.din_up = '0;
        clear_counts();

        // 1: lone requester, every 4 cycles, tokens 0,1,2,...
        phase = 1; fail_rate = 0; spurious_en = 0; tok_limit = 1 << 30;
        do_reset();
        bus.req_dn = 4'b0001;
        repeat (40) @(posedge clk);
        #1;
        check("p1_count", 32'(delivered), 32'd10);
        check("p1_port0", 32'(port_cnt[0]), 32'd10);
        phase = 0;

        // 2: all four requesting, 4000 tokens in 16000 cycles
        tok_limit = 4000;
        do_reset();
        bus.req_dn = 4'b1111;
        wait_delivered(4000, 16100, "p2_delivered");
        check("p2_within_16000", 32'(last_obs - rel_cyc <= 16000), 32'd1);
        for (int i = 0; i < NR; i++) check("p2_per_port", 32'(port_cnt[i]), 32'd1000);

        // 3: sparse requests 1010
        tok_limit = 4;
        do_reset();
        bus.req_dn = 4'b1010;
        wait_delivered(4, 60, "p3_delivered");
        check("p3_port1", 32'(port_cnt[1]), 32'd2);
        check("p3_port3", 32'(port_cnt[3]), 32'd2);

        // 4: random requests, stalling producer, stray acks outside WAIT
        tok_limit = 1 << 30; fail_rate = 50; spurious_en = 1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(3) == 0) bus.req_dn = 4'($urandom_range(15));
        end
        drain("p4_drain");
        check("p4_progress", 32'(delivered > 100), 32'd1);
        spurious_en = 0; fail_rate = 0;

        // 5: port 2 drops its request right after being granted
        tok_limit = 2;
        do_reset();
        bus.req_dn = 4'b0100;
        wait_req_up(20, 1, "p5_grant");
        bus.req_dn = 4'b1000;
        wait_delivered(2, 40, "p5_delivered");
        check("p5_port2", 32'(port_cnt[2]), 32'd1);
        check("p5_port3", 32'(port_cnt[3]), 32'd1);

        // 6a: reset while waiting on a stalled producer
        tok_limit = 1 << 30; fail_rate = 100;
        do_reset();
        bus.req_dn = 4'b1111;
        wait_req_up(20, 3, "p6a_wait");
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("p6a");
        clear_counts();
        fail_rate = 0; tok_limit = 2;
        wait_delivered(2, 40, "p6a_delivered");
        check("p6a_port0", 32'(port_cnt[0]), 32'd1);
        check("p6a_port1", 32'(port_cnt[1]), 32'd1);

        // 6b: reset on the very edge the producer acks; that token must vanish
        tok_limit = 1 << 30;
        do_reset();
        cnt        = 32'h100;
        bus.req_dn = 4'b1111;
        k = 0;
        do begin
            @(posedge clk);
            #3;
            k++;
        end while (!bus.ack_up && k < 20);
        check("p6b_ack_seen", 32'(bus.ack_up), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_outputs("p6b");
        clear_counts();
        tok_limit = 1;
        wait_delivered(1, 40, "p6b_delivered");
        check("p6b_first_port0", 32'(port_cnt[0]), 32'd1);
        check("p6b_token", 32'(last_tok[0]), 32'h101);

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end
endmodule
